// File: rtl/quantum_pkg.sv
// Shared definitions for the quantum gate-program sequencer: opcodes,
// instruction field layout and the sequencer state encoding.
package quantum_pkg;

  localparam int INSTR_W = 7;
  localparam int OP_MSB  = 6;
  localparam int OP_LSB  = 4;
  localparam int Q1_MSB  = 3;
  localparam int Q1_LSB  = 2;
  localparam int Q2_MSB  = 1;
  localparam int Q2_LSB  = 0;

  localparam logic [2:0] OP_H    = 3'b000;
  localparam logic [2:0] OP_X    = 3'b001;
  localparam logic [2:0] OP_CNOT = 3'b010;
  localparam logic [2:0] OP_NOP  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Only real gates count towards gate_count; 011-110 pass through as NOPs.
  function automatic logic is_gate(input logic [2:0] op);
    return (op == OP_H) || (op == OP_X) || (op == OP_CNOT);
  endfunction

endpackage

// File: rtl/quantum_prog_mem.sv
// Program store: PROG_DEPTH x 7-bit register array, synchronous write,
// asynchronous read, no reset so the program survives reset_n.
module quantum_prog_mem
  import quantum_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/quantum_sequencer.sv
// Gate-program sequencer: pulses core_reset, then streams the stored program
// to quantum_core one word per clock until HALT or the last slot.
// Optional single-step mode (adds input step) is enabled by QSEQ_SINGLE_STEP_EN.
module quantum_sequencer
  import quantum_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = $clog2(PROG_DEPTH),
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               abort,
`ifdef QSEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               core_reset,
  output logic [2:0]         core_opcode,
  output logic [1:0]         core_qubit1,
  output logic [1:0]         core_qubit2,
  output logic               busy,
  output logic               done,
  output logic               prog_err,
  output logic [CNT_W-1:0]   gate_count,
  output seq_state_t         state_dbg
);

  // Handshake: start and abort are sampled every rising edge; start acts only
  // in IDLE without abort, abort acts only in INIT/RUN. No ready/ack is returned.
  seq_state_t         state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic               last, last_nxt;
  logic               core_reset_nxt, busy_nxt, done_nxt;
  logic [2:0]         op_nxt;
  logic [1:0]         q1_nxt, q2_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [INSTR_W-1:0] word;
  logic [2:0]         word_op;
  logic               running, adv, mem_we;

`ifdef QSEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign running   = (state == INIT) || (state == RUN);
  assign mem_we    = prog_we && !running;
  assign word_op   = word[OP_MSB:OP_LSB];
  assign state_dbg = state;

  quantum_prog_mem #(
    .PROG_DEPTH(PROG_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc),
    .rdata(word)
  );

  // Outputs are registered from the state being entered, so each RUN cycle
  // shows mem[pc] fetched at the preceding edge; last marks a terminal word.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    last_nxt       = 1'b0;
    core_reset_nxt = 1'b0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    op_nxt         = OP_NOP;
    q1_nxt         = 2'b00;
    q2_nxt         = 2'b00;
    cnt_nxt        = gate_count;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt      = INIT;
          pc_nxt         = '0;
          cnt_nxt        = '0;
          core_reset_nxt = 1'b1;
          busy_nxt       = 1'b1;
        end
      end
      INIT, RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if ((state == RUN) && last) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = RUN;
          busy_nxt  = 1'b1;
          if (adv) begin
            if (word_op == OP_HALT) begin
              last_nxt = 1'b1;
            end else begin
              op_nxt = word_op;
              q1_nxt = word[Q1_MSB:Q1_LSB];
              q2_nxt = word[Q2_MSB:Q2_LSB];
              if (is_gate(word_op) && (gate_count != '1)) cnt_nxt = gate_count + 1'b1;
              if (&pc) last_nxt = 1'b1;
              else     pc_nxt   = pc + 1'b1;
            end
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      last        <= 1'b0;
      core_reset  <= 1'b0;
      core_opcode <= OP_NOP;
      core_qubit1 <= 2'b00;
      core_qubit2 <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
      prog_err    <= 1'b0;
      gate_count  <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      last        <= last_nxt;
      core_reset  <= core_reset_nxt;
      core_opcode <= op_nxt;
      core_qubit1 <= q1_nxt;
      core_qubit2 <= q2_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      gate_count  <= cnt_nxt;
      if (prog_we && running) prog_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quantum_sequencer.sv
// Self-checking bench for quantum_sequencer: randomized programs are walked by
// a program-level reference model and compared cycle by cycle with the DUT.
module tb_quantum_sequencer;
  import quantum_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 8;
  localparam int OW    = 10;
  localparam logic [6:0] NOP_W = {3'b011, 4'b0000};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [6:0]    prog_data = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          core_reset, busy, done, prog_err;
  logic [2:0]    core_opcode;
  logic [1:0]    core_qubit1, core_qubit2;
  logic [CW-1:0] gate_count;
  seq_state_t    state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0]    prog_m [DEPTH];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs_q[$];

  always #5 clk = ~clk;

  quantum_sequencer #(.PROG_DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .abort      (abort),
`ifdef QSEQ_SINGLE_STEP_EN
    .step       (1'b1),
`endif
    .core_reset (core_reset),
    .core_opcode(core_opcode),
    .core_qubit1(core_qubit1),
    .core_qubit2(core_qubit2),
    .busy       (busy),
    .done       (done),
    .prog_err   (prog_err),
    .gate_count (gate_count),
    .state_dbg  (state_dbg)
  );

  function automatic logic [OW-1:0] obs_now();
    return {core_reset, busy, done, core_opcode, core_qubit1, core_qubit2};
  endfunction

  // Reference: INIT cycle, each word up to HALT or the last slot, a NOP for
  // HALT, the done cycle, then one idle cycle. Returns the expected gate count.
  function automatic int build_exp();
    int gates = 0;
    exp_q.delete();
    exp_q.push_back({3'b110, NOP_W});
    for (int a = 0; a < DEPTH; a++) begin
      if (prog_m[a][6:4] == 3'b111) begin
        exp_q.push_back({3'b010, NOP_W});
        break;
      end
      exp_q.push_back({3'b010, prog_m[a]});
      if (prog_m[a][6:4] <= 3'd2) gates++;
    end
    exp_q.push_back({3'b001, NOP_W});
    exp_q.push_back({3'b000, NOP_W});
    return (gates > 255) ? 255 : gates;
  endfunction

  task automatic load_prog();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = AW'(a); prog_data = prog_m[a];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic rand_prog();
    for (int a = 0; a < DEPTH; a++)
      prog_m[a] = {3'($urandom_range(0, 6)), 4'($urandom_range(0, 15))};
  endtask

  // Monitor: issue start (optionally with a write), record outputs from the
  // INIT cycle through the cycle after done, bounded to 48 cycles.
  task automatic run_capture(input bit wr, input logic [6:0] wd);
    bit got_done = 1'b0;
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; prog_we = wr; prog_addr = '0; prog_data = wd;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    for (int c = 0; c < 48; c++) begin
      obs_q.push_back(obs_now());
      if (got_done) break;
      if (done) got_done = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_now() !== {3'b000, NOP_W}) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected %h", obs_now(), {3'b000, NOP_W});
    end
    vectors++;
    if ({prog_err, gate_count} !== 9'd0) begin
      miscompares++; $display("FAIL reset_err_cnt: got %h expected 0", {prog_err, gate_count});
    end
    vectors++;
    if (state_dbg !== IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int exp_cnt;
    rand_prog();
    prog_m[0] = {3'b000, 2'b00, 2'($urandom_range(0, 3))};
    prog_m[1] = {3'b010, 2'b00, 2'b01};
    prog_m[2] = {3'b111, 4'($urandom_range(0, 15))};
    load_prog();
    exp_cnt = build_exp();
    run_capture(1'b0, 7'd0);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL basic_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL basic_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (gate_count !== CW'(exp_cnt)) begin
      miscompares++; $display("FAIL basic_count: got %0d expected %0d", gate_count, exp_cnt);
    end
  endtask

  task automatic test_write_with_start();
    int exp_cnt;
    logic [6:0] nw;
    nw = {3'b001, 4'($urandom_range(0, 15))};
    prog_m[0] = nw;
    exp_cnt = build_exp();
    run_capture(1'b1, nw);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL wrstart_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL wrstart_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (gate_count !== CW'(exp_cnt)) begin
      miscompares++; $display("FAIL wrstart_count: got %0d expected %0d", gate_count, exp_cnt);
    end
  endtask

  task automatic test_implicit_halt();
    int exp_cnt;
    for (int a = 0; a < DEPTH; a++) prog_m[a] = {3'b001, 2'b01, 2'b00};
    load_prog();
    exp_cnt = build_exp();
    run_capture(1'b0, 7'd0);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL implicit_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL implicit_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (gate_count !== CW'(exp_cnt)) begin
      miscompares++; $display("FAIL implicit_count: got %0d expected %0d", gate_count, exp_cnt);
    end
  endtask

  task automatic test_nop();
    int exp_cnt;
    rand_prog();
    prog_m[0] = {3'b001, 4'($urandom_range(0, 15))};
    prog_m[1] = {3'b100, 4'($urandom_range(0, 15))};
    prog_m[2] = {3'b111, 4'b0000};
    load_prog();
    exp_cnt = build_exp();
    run_capture(1'b0, 7'd0);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL nop_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL nop_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (gate_count !== CW'(exp_cnt)) begin
      miscompares++; $display("FAIL nop_count: got %0d expected %0d", gate_count, exp_cnt);
    end
  endtask

  task automatic test_random();
    int exp_cnt, h;
    for (int it = 0; it < 6; it++) begin
      rand_prog();
      h = $urandom_range(0, 16);
      if (h < DEPTH) prog_m[h] = {3'b111, 4'($urandom_range(0, 15))};
      load_prog();
      exp_cnt = build_exp();
      run_capture(1'b0, 7'd0);
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
        miscompares++; $display("FAIL rand%0d_len: got %0d expected %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rand%0d_cyc%0d: got %h expected %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (gate_count !== CW'(exp_cnt)) begin
        miscompares++; $display("FAIL rand%0d_count: got %0d expected %0d", it, gate_count, exp_cnt);
      end
    end
  endtask

  task automatic test_abort();
    int exp_cnt = 0;
    rand_prog();
    for (int a = 0; a < 5; a++) prog_m[a] = {3'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
    prog_m[5] = {3'b111, 4'b0000};
    load_prog();
    for (int a = 0; a < 2; a++) if (prog_m[a][6:4] <= 3'd2) exp_cnt++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    vectors++;
    if (obs_now() !== {3'b010, prog_m[1]}) begin
      miscompares++; $display("FAIL abort_second_gate: got %h expected %h", obs_now(), {3'b010, prog_m[1]});
    end
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (obs_now() !== {3'b000, NOP_W}) begin
      miscompares++; $display("FAIL abort_outputs: got %h expected %h", obs_now(), {3'b000, NOP_W});
    end
    vectors++;
    if (gate_count !== CW'(exp_cnt)) begin
      miscompares++; $display("FAIL abort_count: got %0d expected %0d", gate_count, exp_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++; $display("FAIL abort_idle%0d: got busy/done %b expected 00", c, {busy, done});
      end
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    vectors++;
    if ({core_reset, busy, state_dbg} !== {2'b00, IDLE}) begin
      miscompares++; $display("FAIL start_abort: got %b expected %b", {core_reset, busy, state_dbg}, {2'b00, IDLE});
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL start_abort_next: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_prog_err();
    int exp_cnt;
    rand_prog();
    prog_m[7] = {3'b111, 4'b0000};
    load_prog();
    exp_cnt = build_exp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = '0; prog_data = ~prog_m[0];
    @(negedge clk);
    prog_we = 1'b0;
    vectors++;
    if (prog_err !== 1'b1) begin
      miscompares++; $display("FAIL prog_err_set: got %b expected 1", prog_err);
    end
    for (int c = 0; c < 30; c++) begin
      if (done) break;
      @(negedge clk);
    end
    @(negedge clk);
    run_capture(1'b0, 7'd0);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL progerr_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL progerr_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ({prog_err, gate_count} !== {1'b1, CW'(exp_cnt)}) begin
      miscompares++; $display("FAIL progerr_sticky: got %h expected %h", {prog_err, gate_count}, {1'b1, CW'(exp_cnt)});
    end
  endtask

  task automatic test_reset_mid_run();
    int exp_cnt;
    exp_cnt = build_exp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs_now() !== {3'b000, NOP_W}) begin
      miscompares++; $display("FAIL midreset_outputs: got %h expected %h", obs_now(), {3'b000, NOP_W});
    end
    vectors++;
    if ({prog_err, gate_count} !== 9'd0) begin
      miscompares++; $display("FAIL midreset_err_cnt: got %h expected 0", {prog_err, gate_count});
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_capture(1'b0, 7'd0);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL replay_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL replay_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (gate_count !== CW'(exp_cnt)) begin
      miscompares++; $display("FAIL replay_count: got %0d expected %0d", gate_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_with_start();
    test_implicit_halt();
    test_nop();
    test_random();
    test_abort();
    test_start_abort_idle();
    test_prog_err();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/quantum_sequencer.md
Name: quantum_sequencer

Overview:
- Gate-program sequencer for quantum_core.
- Holds a small loadable program of gate instructions.
- On start: pulses the core's reset to re-initialise |00>, then issues one instruction per clock on the core's opcode/qubit1/qubit2 inputs until HALT or end of program.
- Reports busy, done and the number of gates issued.

Parameters:
- PROG_DEPTH, 16, number of instruction slots; power of two, at least 2.
- ADDR_W, $clog2(PROG_DEPTH), program address width.
- CNT_W, 8, width of gate_count.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- prog_we  input  1  program write strobe.
- prog_addr  input  ADDR_W  program write address.
- prog_data  input  7  instruction {opcode[6:4], qubit1[3:2], qubit2[1:0]}.
- start  input  1  single-cycle run request.
- abort  input  1  stop run immediately.
- core_reset  output  1  active-high reset to quantum_core.
- core_opcode  output  3  opcode to core.
- core_qubit1  output  2  qubit1/control to core.
- core_qubit2  output  2  qubit2/target to core.
- busy  output  1  high in INIT and RUN.
- done  output  1  one-cycle pulse at program completion.
- prog_err  output  1  sticky: write attempted while busy.
- gate_count  output  CNT_W  gates issued in current/last run.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=0.
  - core_reset=0, core_opcode=3'b011 (NOP), core_qubit1=0, core_qubit2=0.
  - busy=0, done=0, prog_err=0, gate_count=0.
  - Program contents are not reset.
- Opcodes:
  - 000 H, 001 X, 010 CNOT are forwarded to the core.
  - 011-110 are NOP: forwarded as-is, not counted.
  - 111 HALT is sequencer-only and never reaches the core; 3'b011 is output instead.
- Registers: all outputs are registered. Program read is asynchronous from pc.
- States:
  - IDLE: core_opcode=NOP. start=1 and abort=0 -> INIT; pc<=0, gate_count<=0.
  - INIT: exactly one cycle. core_reset=1, core_opcode=NOP, busy=1. -> RUN.
  - RUN: each cycle the outputs are loaded from mem[pc].
    - Non-HALT word: pc<=pc+1; gate_count increments for opcodes 000/001/010 and saturates at all-ones.
    - HALT word: outputs NOP; -> DONE.
    - Word at pc=PROG_DEPTH-1 that is not HALT: issued normally, then -> DONE. This is an implicit halt; pc never wraps.
  - DONE: done=1 for one cycle, busy=0, core_opcode=NOP. -> IDLE.
- Latency: start sampled at edge N. Then:
  - core_reset=1 during cycle N+1.
  - First instruction presented during N+2; the core applies it at edge N+3.
  - k gates followed by HALT: done is high k+3 cycles after start.
- abort:
  - In INIT or RUN: next edge -> IDLE, outputs NOP, core_reset=0, busy=0, no done pulse. gate_count holds its value.
  - In IDLE or DONE: no effect.
  - Simultaneous with start in IDLE: abort wins.
- start while busy or in DONE: ignored.
- prog_we:
  - When state is IDLE or DONE: writes mem[prog_addr]<=prog_data at the edge.
  - When busy: the write is dropped and prog_err<=1. prog_err clears only on reset.
  - prog_we and start in the same IDLE cycle: the write takes effect before the first fetch.
- reset_n low mid-run: everything returns to reset values asynchronously; the program is retained.

Optional Feature:
- Macro: QSEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - In RUN, an instruction is fetched, issued and pc advanced only on cycles with step=1.
  - On other cycles the outputs show NOP and pc holds.
  - HALT is also processed only on a step cycle.
  - INIT timing is unchanged.
- Undefined: no step port; RUN advances every cycle as specified above.

Decomposition:
- Package quantum_pkg:
  - Opcode localparams: OP_H=3'b000, OP_X=3'b001, OP_CNOT=3'b010, OP_NOP=3'b011, OP_HALT=3'b111.
  - Instruction field bit positions and width 7.
  - State encoding enum: IDLE, INIT, RUN, DONE.
- Sub-module quantum_prog_mem:
  - PROG_DEPTH x 7 register array.
  - Synchronous write, asynchronous read, no reset.
  - Write gating is done by the sequencer.

Test Plan:
- Program {0:H q1=0, 1:CNOT q1=0 q2=1, 2:HALT}, start:
  - core_reset high 1 cycle.
  - Cycles N+2..N+3 show 000/00/xx then 010/00/01; then NOP.
  - done at N+5; gate_count=2; quantum_core output 0x05000005.
- Program 16 X q1=1 words with no HALT:
  - 16 X issued, implicit halt at pc=15.
  - done one cycle after the last issue; gate_count=16.
- Program {0:X, 1:NOP 3'b100, 2:HALT}: gate_count=1; opcode 3'b100 appears on core_opcode for one cycle.
- Abort asserted the cycle the second of five gates is presented:
  - Next cycle busy=0, core_opcode=NOP, no done pulse.
  - gate_count holds its value at the abort edge.
- prog_we during RUN: mem unchanged (re-run gives identical trace); prog_err=1 until reset_n low.
- start and abort together in IDLE: stays IDLE. reset_n low mid-RUN: all outputs at reset values immediately; a re-run replays the retained program.
